serial_adder: RTL and testbench

- Bit-serial adder: accepts two WIDTH-bit operands plus carry-in in parallel, then adds them LSB-first over WIDTH cycles.
- Each cycle evaluates one full-adder bit slice: s = a^b^c, c' = (a&b)|(b&c)|(c&a). The carry is held in a flip-flop between cycles.
- Sits where a ripple chain of full adders is too large. Offers valid/ready on both sides so it can be chained between register stages.

---
 rtl/serial_adder.sv | 125 ++++++++++++
 tb/tb_serial_adder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder with valid/ready handshakes.
// Operands are captured in parallel, then summed LSB-first, one full-adder
// slice per clock, with the carry held in a flip-flop between slices.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] sumSh_q, sumSh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             sBit;
  logic             cBit;
  logic [WIDTH-1:0] sumShifted;

  // One full-adder slice over the current LSBs and the held carry.
  always_comb begin
    sBit       = aSh_q[0] ^ bSh_q[0] ^ carry_q;
    cBit       = (aSh_q[0] & bSh_q[0]) | (bSh_q[0] & carry_q) | (carry_q & aSh_q[0]);
    sumShifted = {sBit, sumSh_q[WIDTH-1:1]};
  end

  // State and datapath registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      sumSh_q <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      sumSh_q <= sumSh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: capture in IDLE, shift one slice per RUN cycle, publish on the last slice.
  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    sumSh_d = sumSh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    co_d    = co_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          aSh_d   = a;
          bSh_d   = b;
          carry_d = ci;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        aSh_d   = {1'b0, aSh_q[WIDTH-1:1]};
        bSh_d   = {1'b0, bSh_q[WIDTH-1:1]};
        sumSh_d = sumShifted;
        carry_d = cBit;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = sumShifted;
          co_d    = cBit;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs depend only on registered state, never on in_valid/out_ready.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == RUN);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    co        = co_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder at
// WIDTH=8 and WIDTH=16 against plain a+b+ci arithmetic.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  logic        inValid8, inReady8, outValid8, outReady8, ci8, co8, busy8;
  logic [7:0]  a8, b8, sum8;
  logic        inValid16, inReady16, outValid16, outReady16, ci16, co16, busy16;
  logic [15:0] a16, b16, sum16;

  int assertCount = 0;
  int failCount   = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(inValid8), .in_ready(inReady8),
    .a(a8), .b(b8), .ci(ci8),
    .out_valid(outValid8), .out_ready(outReady8),
    .sum(sum8), .co(co8), .busy(busy8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(inValid16), .in_ready(inReady16),
    .a(a16), .b(b16), .ci(ci16),
    .out_valid(outValid16), .out_ready(outReady16),
    .sum(sum16), .co(co16), .busy(busy16)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set to the 8-bit DUT for exactly one accept edge.
  task automatic applyStimulus(input logic [7:0] aVal, input logic [7:0] bVal, input logic ciVal);
    int guard = 0;
    while (!inReady8 && guard < 50) begin
      tick();
      guard++;
    end
    checkOutput("inReadyBeforeAccept", 64'(inReady8), 64'd1);
    a8       = aVal;
    b8       = bVal;
    ci8      = ciVal;
    inValid8 = 1'b1;
    tick();
    inValid8 = 1'b0;
    a8       = 8'($urandom);
    b8       = 8'($urandom);
    ci8      = 1'($urandom);
  endtask

  // Full operation with out_ready pre-asserted: latency, busy span, result, one-cycle DONE.
  task automatic runOp8(input logic [7:0] aVal, input logic [7:0] bVal, input logic ciVal, input string tag);
    logic [8:0] expected;
    int lat = 0;
    int busyCycles = 0;
    expected  = 9'(aVal) + 9'(bVal) + 9'(ciVal);
    outReady8 = 1'b1;
    applyStimulus(aVal, bVal, ciVal);
    while (!outValid8 && lat < 40) begin
      if (busy8) busyCycles++;
      tick();
      lat++;
    end
    checkOutput({tag, ".latency"}, 64'(lat), 64'd8);
    checkOutput({tag, ".busyCycles"}, 64'(busyCycles), 64'd8);
    checkOutput({tag, ".result"}, 64'({co8, sum8}), 64'(expected));
    tick();
    checkOutput({tag, ".doneOneCycle"}, 64'(outValid8), 64'd0);
    checkOutput({tag, ".backToIdle"}, 64'(inReady8), 64'd1);
  endtask

  // Random streaming on the 8-bit DUT with a queue of expected results.
  task automatic streamW8();
    logic [8:0] q[$];
    logic [8:0] exp9;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while (got < 1000 && cyc < 40000) begin
      outReady8 = ($urandom_range(0, 3) != 0);
      if (outValid8 && outReady8) begin
        checkOutput("w8.resultExpected", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          exp9 = q.pop_front();
          checkOutput("w8.result", 64'({co8, sum8}), 64'(exp9));
        end
        got++;
      end
      inValid8 = (sent < 1000) && ($urandom_range(0, 3) != 0);
      a8       = 8'($urandom);
      b8       = 8'($urandom);
      ci8      = 1'($urandom);
      if (inValid8 && inReady8) begin
        exp9 = 9'(a8) + 9'(b8) + 9'(ci8);
        q.push_back(exp9);
        sent++;
      end
      tick();
      cyc++;
    end
    checkOutput("w8.resultCount", 64'(got), 64'd1000);
    checkOutput("w8.queueDrained", 64'(q.size()), 64'd0);
    inValid8  = 1'b0;
    outReady8 = 1'b0;
  endtask

  // Random streaming on the 16-bit DUT with a queue of expected results.
  task automatic streamW16();
    logic [16:0] q[$];
    logic [16:0] exp17;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while (got < 1000 && cyc < 60000) begin
      outReady16 = ($urandom_range(0, 3) != 0);
      if (outValid16 && outReady16) begin
        checkOutput("w16.resultExpected", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          exp17 = q.pop_front();
          checkOutput("w16.result", 64'({co16, sum16}), 64'(exp17));
        end
        got++;
      end
      inValid16 = (sent < 1000) && ($urandom_range(0, 3) != 0);
      a16       = 16'($urandom);
      b16       = 16'($urandom);
      ci16      = 1'($urandom);
      if (inValid16 && inReady16) begin
        exp17 = 17'(a16) + 17'(b16) + 17'(ci16);
        q.push_back(exp17);
        sent++;
      end
      tick();
      cyc++;
    end
    checkOutput("w16.resultCount", 64'(got), 64'd1000);
    checkOutput("w16.queueDrained", 64'(q.size()), 64'd0);
    inValid16  = 1'b0;
    outReady16 = 1'b0;
  endtask

  // Hard stop if something hangs beyond every bounded loop.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed cases, backpressure, mid-op reset, streaming.
  initial begin
    rst = 1'b1;
    inValid8 = 1'b0;  outReady8 = 1'b0;  a8 = '0;  b8 = '0;  ci8 = 1'b0;
    inValid16 = 1'b0; outReady16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("reset.inReady", 64'(inReady8), 64'd1);
    checkOutput("reset.outValid", 64'(outValid8), 64'd0);
    checkOutput("reset.busy", 64'(busy8), 64'd0);
    checkOutput("reset.sum", 64'(sum8), 64'd0);
    checkOutput("reset.co", 64'(co8), 64'd0);
    checkOutput("reset16.state", 64'({inReady16, outValid16, busy16}), 64'b100);
    checkOutput("reset16.result", 64'({co16, sum16}), 64'd0);

    runOp8(8'h5A, 8'h33, 1'b0, "basic");
    checkOutput("basic.sumHeld", 64'(sum8), 64'h8D);
    runOp8(8'hFF, 8'h01, 1'b0, "carryFF01");
    runOp8(8'hFF, 8'hFF, 1'b1, "carryFFFF");
    runOp8(8'h00, 8'h00, 1'b1, "carryIn");
    for (int i = 0; i < 4; i++) begin
      runOp8(8'($urandom), 8'($urandom), 1'($urandom), "directedRandom");
    end

    // Backpressure: result must hold while a competing operand is offered.
    outReady8 = 1'b0;
    applyStimulus(8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 40 && !outValid8; i++) tick();
    checkOutput("bp.outValidRose", 64'(outValid8), 64'd1);
    a8 = 8'hAA;
    b8 = 8'hBB;
    inValid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp.sumStable", 64'({co8, sum8}), 64'h046);
      checkOutput("bp.outValidHeld", 64'(outValid8), 64'd1);
      checkOutput("bp.inReadyLow", 64'(inReady8), 64'd0);
      tick();
    end
    inValid8  = 1'b0;
    outReady8 = 1'b1;
    tick();
    checkOutput("bp.released", 64'({inReady8, outValid8, busy8}), 64'b100);
    checkOutput("bp.sumKept", 64'(sum8), 64'h46);
    tick();
    checkOutput("bp.competitorNotCaptured", 64'(busy8), 64'd0);

    // Reset in the middle of RUN aborts without presenting anything.
    applyStimulus(8'h0F, 8'h01, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("midReset.stillBusy", 64'(busy8), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midReset.state", 64'({inReady8, outValid8, busy8}), 64'b100);
    checkOutput("midReset.cleared", 64'({co8, sum8}), 64'd0);
    runOp8(8'h80, 8'h80, 1'b0, "afterReset");

    fork
      streamW8();
      streamW16();
    join

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
